// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with per-state memory wait counting and timeout.
// Define MC_JAL_EN to decode JAL (opcode 0x03) as a linking jump; otherwise 0x03 is illegal.
module multicycle_control #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       instr_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       invert_zero,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       link,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [3:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       halted,
  output logic       err_illegal,
  output logic       err_timeout
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, IMMEX, IMMWB, BRANCH, JUMP, HALT
  } state_e;

  localparam logic [3:0] ALU_undef = 4'h0;
  localparam logic [3:0] ALU_AND   = 4'h1;
  localparam logic [3:0] ALU_OR    = 4'h2;
  localparam logic [3:0] ALU_add   = 4'h3;
  localparam logic [3:0] ALU_sub   = 4'h4;
  localparam logic [3:0] ALU_slt   = 4'h5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_illegal_q, err_illegal_d;
  logic       err_timeout_q, err_timeout_d;
  logic       in_mem;
`ifdef MC_JAL_EN
  logic       link_q, link_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      wait_q        <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef MC_JAL_EN
      link_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
`ifdef MC_JAL_EN
      link_q        <= link_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
`ifdef MC_JAL_EN
    link_d        = link_q;
`endif
    in_mem        = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    invert_zero   = 1'b0;
    regdst        = 1'b0;
    regwrite      = 1'b0;
    memtoreg      = 1'b0;
    link          = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = 2'd0;
    aluop         = ALU_undef;
    pcsrc         = 2'd0;
    halted        = 1'b0;

    case (state_q)
      FETCH: begin
        in_mem   = 1'b1;
        mem_req  = 1'b1;
        alusrc_b = 2'd1;
        aluop    = ALU_add;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alusrc_b = 2'd3;
        aluop    = ALU_add;
`ifdef MC_JAL_EN
        link_d   = 1'b0;
`endif
        if (instr_zero) begin
          state_d = HALT;
        end else begin
          case (opcode)
            OP_RTYPE:        state_d = EXEC;
            OP_LW, OP_SW:    state_d = MEMADR;
            OP_ADDI, OP_ORI: state_d = IMMEX;
            OP_BEQ, OP_BNE:  state_d = BRANCH;
            OP_J:            state_d = JUMP;
`ifdef MC_JAL_EN
            OP_JAL: begin
              state_d = JUMP;
              link_d  = 1'b1;
            end
`endif
            default: begin
              state_d       = HALT;
              err_illegal_d = 1'b1;
            end
          endcase
        end
      end
      MEMADR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        aluop    = ALU_add;
        state_d  = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        in_mem  = 1'b1;
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        in_mem    = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXEC: begin
        alusrc_a = 1'b1;
        state_d  = ALUWB;
        case (funct)
          6'h20:   aluop = ALU_add;
          6'h22:   aluop = ALU_sub;
          6'h24:   aluop = ALU_AND;
          6'h25:   aluop = ALU_OR;
          6'h2A:   aluop = ALU_slt;
          default: begin
            state_d       = HALT;
            err_illegal_d = 1'b1;
          end
        endcase
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      IMMEX: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'd2;
        aluop    = (opcode == OP_ORI) ? ALU_OR : ALU_add;
        state_d  = IMMWB;
      end
      IMMWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrc_a      = 1'b1;
        aluop         = ALU_sub;
        pc_write_cond = 1'b1;
        pcsrc         = 2'd1;
        invert_zero   = (opcode == OP_BNE);
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pcsrc    = 2'd2;
`ifdef MC_JAL_EN
        link     = link_q;
        regwrite = link_q;
`endif
        state_d  = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Shared wait accounting for the three states that hold a memory request open
    if (in_mem && !mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d       = HALT;
        err_timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end

    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      regwrite      = 1'b0;
    end
  end

  assign state       = state_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Vector-table plus scoreboard bench for multicycle_control; two instances (MAX_WAIT 15 and 4) share stimulus.
// Honours MC_JAL_EN so the opcode 0x03 expectations track the build.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_IMMEX  = 4'd8;
  localparam logic [3:0] S_IMMWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam logic [3:0] A_UNDEF = 4'h0;
  localparam logic [3:0] A_AND   = 4'h1;
  localparam logic [3:0] A_OR    = 4'h2;
  localparam logic [3:0] A_ADD   = 4'h3;
  localparam logic [3:0] A_SUB   = 4'h4;
  localparam logic [3:0] A_SLT   = 4'h5;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       invert_zero;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       link;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
    logic [3:0] state;
    logic       halted;
    logic       err_illegal;
    logic       err_timeout;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       instr_zero;
    logic       mem_ready;
    outs_t      exp;
  } vec_t;

  typedef struct {
    string name;
    bit    sel4;
    outs_t exp;
  } sb_t;

  localparam outs_t E_FRST = '{alusrc_b:2'd1, aluop:A_ADD, state:S_FETCH, default:'0};
  localparam outs_t E_FR   = '{mem_req:1'b1, ir_write:1'b1, pc_write:1'b1, alusrc_b:2'd1,
                               aluop:A_ADD, state:S_FETCH, default:'0};
  localparam outs_t E_FW   = '{mem_req:1'b1, alusrc_b:2'd1, aluop:A_ADD, state:S_FETCH, default:'0};
  localparam outs_t E_DEC  = '{alusrc_b:2'd3, aluop:A_ADD, state:S_DECODE, default:'0};
  localparam outs_t E_MADR = '{alusrc_a:1'b1, alusrc_b:2'd2, aluop:A_ADD, state:S_MEMADR, default:'0};
  localparam outs_t E_MRD  = '{mem_req:1'b1, iord:1'b1, state:S_MEMRD, default:'0};
  localparam outs_t E_MWB  = '{regwrite:1'b1, memtoreg:1'b1, state:S_MEMWB, default:'0};
  localparam outs_t E_MWR  = '{mem_req:1'b1, mem_write:1'b1, iord:1'b1, state:S_MEMWR, default:'0};
  localparam outs_t E_XSUB = '{alusrc_a:1'b1, aluop:A_SUB, state:S_EXEC, default:'0};
  localparam outs_t E_XSLT = '{alusrc_a:1'b1, aluop:A_SLT, state:S_EXEC, default:'0};
  localparam outs_t E_XAND = '{alusrc_a:1'b1, aluop:A_AND, state:S_EXEC, default:'0};
  localparam outs_t E_XBAD = '{alusrc_a:1'b1, aluop:A_UNDEF, state:S_EXEC, default:'0};
  localparam outs_t E_AWB  = '{regwrite:1'b1, regdst:1'b1, state:S_ALUWB, default:'0};
  localparam outs_t E_IOR  = '{alusrc_a:1'b1, alusrc_b:2'd2, aluop:A_OR, state:S_IMMEX, default:'0};
  localparam outs_t E_IADD = '{alusrc_a:1'b1, alusrc_b:2'd2, aluop:A_ADD, state:S_IMMEX, default:'0};
  localparam outs_t E_IWB  = '{regwrite:1'b1, state:S_IMMWB, default:'0};
  localparam outs_t E_BNE  = '{alusrc_a:1'b1, aluop:A_SUB, pc_write_cond:1'b1, pcsrc:2'd1,
                               invert_zero:1'b1, state:S_BRANCH, default:'0};
  localparam outs_t E_BEQ  = '{alusrc_a:1'b1, aluop:A_SUB, pc_write_cond:1'b1, pcsrc:2'd1,
                               state:S_BRANCH, default:'0};
  localparam outs_t E_JMP  = '{pc_write:1'b1, pcsrc:2'd2, state:S_JUMP, default:'0};
  localparam outs_t E_JAL  = '{pc_write:1'b1, pcsrc:2'd2, link:1'b1, regwrite:1'b1,
                               state:S_JUMP, default:'0};
  localparam outs_t E_HLT  = '{halted:1'b1, state:S_HALT, default:'0};
  localparam outs_t E_HILL = '{halted:1'b1, err_illegal:1'b1, state:S_HALT, default:'0};
  localparam outs_t E_HTO  = '{halted:1'b1, err_timeout:1'b1, state:S_HALT, default:'0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       instr_zero, mem_ready;

  logic       m_mem_req, m_mem_write, m_iord, m_ir_write, m_pc_write, m_pc_write_cond;
  logic       m_invert_zero, m_regdst, m_regwrite, m_memtoreg, m_link, m_alusrc_a;
  logic [1:0] m_alusrc_b, m_pcsrc;
  logic [3:0] m_aluop, m_state;
  logic       m_halted, m_err_illegal, m_err_timeout;

  logic       t_mem_req, t_mem_write, t_iord, t_ir_write, t_pc_write, t_pc_write_cond;
  logic       t_invert_zero, t_regdst, t_regwrite, t_memtoreg, t_link, t_alusrc_a;
  logic [1:0] t_alusrc_b, t_pcsrc;
  logic [3:0] t_aluop, t_state;
  logic       t_halted, t_err_illegal, t_err_timeout;

  outs_t o_main, o_four;
  sb_t   sb_q[$];
  vec_t  vecs[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .instr_zero(instr_zero), .mem_ready(mem_ready),
    .mem_req(m_mem_req), .mem_write(m_mem_write), .iord(m_iord), .ir_write(m_ir_write),
    .pc_write(m_pc_write), .pc_write_cond(m_pc_write_cond), .invert_zero(m_invert_zero),
    .regdst(m_regdst), .regwrite(m_regwrite), .memtoreg(m_memtoreg), .link(m_link),
    .alusrc_a(m_alusrc_a), .alusrc_b(m_alusrc_b), .aluop(m_aluop), .pcsrc(m_pcsrc),
    .state(m_state), .halted(m_halted), .err_illegal(m_err_illegal),
    .err_timeout(m_err_timeout)
  );

  multicycle_control #(.MAX_WAIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .instr_zero(instr_zero), .mem_ready(mem_ready),
    .mem_req(t_mem_req), .mem_write(t_mem_write), .iord(t_iord), .ir_write(t_ir_write),
    .pc_write(t_pc_write), .pc_write_cond(t_pc_write_cond), .invert_zero(t_invert_zero),
    .regdst(t_regdst), .regwrite(t_regwrite), .memtoreg(t_memtoreg), .link(t_link),
    .alusrc_a(t_alusrc_a), .alusrc_b(t_alusrc_b), .aluop(t_aluop), .pcsrc(t_pcsrc),
    .state(t_state), .halted(t_halted), .err_illegal(t_err_illegal),
    .err_timeout(t_err_timeout)
  );

  assign o_main = {m_mem_req, m_mem_write, m_iord, m_ir_write, m_pc_write, m_pc_write_cond,
                   m_invert_zero, m_regdst, m_regwrite, m_memtoreg, m_link, m_alusrc_a,
                   m_alusrc_b, m_aluop, m_pcsrc, m_state, m_halted, m_err_illegal, m_err_timeout};
  assign o_four = {t_mem_req, t_mem_write, t_iord, t_ir_write, t_pc_write, t_pc_write_cond,
                   t_invert_zero, t_regdst, t_regwrite, t_memtoreg, t_link, t_alusrc_a,
                   t_alusrc_b, t_aluop, t_pcsrc, t_state, t_halted, t_err_illegal, t_err_timeout};

  function automatic vec_t mkv(string n, logic r, logic [5:0] op, logic [5:0] fn,
                               logic iz, logic rdy, outs_t e);
    vec_t v;
    v.name = n; v.rst_n = r; v.opcode = op; v.funct = fn;
    v.instr_zero = iz; v.mem_ready = rdy; v.exp = e;
    return v;
  endfunction

  task automatic checkOutput();
    sb_t   s;
    outs_t got;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty got=none exp=entry");
    end else begin
      s   = sb_q.pop_front();
      got = s.sel4 ? o_four : o_main;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL %s (%s) got=%h exp=%h got_state=%0d exp_state=%0d", s.name,
                 s.sel4 ? "wait4" : "wait15", got, s.exp, got.state, s.exp.state);
      end
    end
  endtask

  // Drive one cycle's inputs on the falling edge, queue the expectation, compare 1ns later
  task automatic applyStimulus(string n, logic r, logic [5:0] op, logic [5:0] fn,
                               logic iz, logic rdy, outs_t e, bit sel4 = 1'b0);
    sb_t s;
    @(negedge clk);
    rst_n = r; opcode = op; funct = fn; instr_zero = iz; mem_ready = rdy;
    s.name = n; s.sel4 = sel4; s.exp = e;
    sb_q.push_back(s);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; instr_zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    vecs.push_back(mkv("reset_forces_strobes", 0, 6'h23, 6'h00, 0, 1, E_FRST));
    vecs.push_back(mkv("lw_fetch",  1, 6'h23, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("lw_decode", 1, 6'h23, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("lw_memadr", 1, 6'h23, 6'h00, 0, 1, E_MADR));
    vecs.push_back(mkv("lw_memrd",  1, 6'h23, 6'h00, 0, 1, E_MRD));
    vecs.push_back(mkv("lw_memwb",  1, 6'h23, 6'h00, 0, 1, E_MWB));
    vecs.push_back(mkv("sub_fetch", 1, 6'h00, 6'h22, 0, 1, E_FR));
    vecs.push_back(mkv("sub_decode",1, 6'h00, 6'h22, 0, 1, E_DEC));
    vecs.push_back(mkv("sub_exec",  1, 6'h00, 6'h22, 0, 1, E_XSUB));
    vecs.push_back(mkv("sub_aluwb", 1, 6'h00, 6'h22, 0, 1, E_AWB));
    vecs.push_back(mkv("sw_fetch",  1, 6'h2B, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("sw_decode", 1, 6'h2B, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("sw_memadr", 1, 6'h2B, 6'h00, 0, 1, E_MADR));
    vecs.push_back(mkv("sw_memwr",  1, 6'h2B, 6'h00, 0, 1, E_MWR));
    vecs.push_back(mkv("ori_fetch", 1, 6'h0D, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("ori_decode",1, 6'h0D, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("ori_immex", 1, 6'h0D, 6'h00, 0, 1, E_IOR));
    vecs.push_back(mkv("ori_immwb", 1, 6'h0D, 6'h00, 0, 1, E_IWB));
    vecs.push_back(mkv("bne_fetch", 1, 6'h05, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("bne_decode",1, 6'h05, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("bne_branch",1, 6'h05, 6'h00, 0, 1, E_BNE));
    vecs.push_back(mkv("beq_fetch", 1, 6'h04, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("beq_decode",1, 6'h04, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("beq_branch",1, 6'h04, 6'h00, 0, 1, E_BEQ));
    vecs.push_back(mkv("j_fetch",   1, 6'h02, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("j_decode",  1, 6'h02, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("j_jump",    1, 6'h02, 6'h00, 0, 1, E_JMP));
    vecs.push_back(mkv("slt_fetch", 1, 6'h00, 6'h2A, 0, 1, E_FR));
    vecs.push_back(mkv("slt_decode",1, 6'h00, 6'h2A, 0, 1, E_DEC));
    vecs.push_back(mkv("slt_exec",  1, 6'h00, 6'h2A, 0, 1, E_XSLT));
    vecs.push_back(mkv("slt_aluwb", 1, 6'h00, 6'h2A, 0, 1, E_AWB));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv("fetch_wait", 1, 6'h08, 6'h00, 0, 0, E_FW));
    vecs.push_back(mkv("fetch_ready_after_wait", 1, 6'h08, 6'h00, 0, 1, E_FR));
    vecs.push_back(mkv("addi_decode",1, 6'h08, 6'h00, 0, 1, E_DEC));
    vecs.push_back(mkv("addi_immex", 1, 6'h08, 6'h00, 0, 1, E_IADD));
    vecs.push_back(mkv("addi_immwb", 1, 6'h08, 6'h00, 0, 1, E_IWB));
    vecs.push_back(mkv("and_fetch",  1, 6'h00, 6'h24, 0, 1, E_FR));
    vecs.push_back(mkv("and_decode", 1, 6'h00, 6'h24, 0, 1, E_DEC));
    vecs.push_back(mkv("and_exec",   1, 6'h00, 6'h24, 0, 1, E_XAND));
    vecs.push_back(mkv("and_aluwb",  1, 6'h00, 6'h24, 0, 1, E_AWB));

    foreach (vecs[i])
      applyStimulus(vecs[i].name, vecs[i].rst_n, vecs[i].opcode, vecs[i].funct,
                    vecs[i].instr_zero, vecs[i].mem_ready, vecs[i].exp);

    // Illegal funct halts with err_illegal; flags persist and reset still wins in HALT
    applyStimulus("badfn_fetch",  1, 6'h00, 6'h3F, 0, 1, E_FR);
    applyStimulus("badfn_decode", 1, 6'h00, 6'h3F, 0, 1, E_DEC);
    applyStimulus("badfn_exec",   1, 6'h00, 6'h3F, 0, 1, E_XBAD);
    applyStimulus("badfn_halt",   1, 6'h00, 6'h3F, 0, 1, E_HILL);
    applyStimulus("badfn_halt_holds", 1, 6'h23, 6'h00, 0, 1, E_HILL);
    applyStimulus("badfn_reset_edge", 0, 6'h23, 6'h00, 0, 1, E_HILL);
    applyStimulus("badfn_after_reset", 1, 6'h3F, 6'h00, 0, 1, E_FR);

    // Unknown opcode straight from decode
    applyStimulus("badop_decode", 1, 6'h3F, 6'h00, 0, 1, E_DEC);
    applyStimulus("badop_halt",   1, 6'h3F, 6'h00, 0, 1, E_HILL);
    applyStimulus("badop_reset",  0, 6'h03, 6'h00, 0, 1, E_HILL);

    applyStimulus("jal_fetch",  1, 6'h03, 6'h00, 0, 1, E_FR);
    applyStimulus("jal_decode", 1, 6'h03, 6'h00, 0, 1, E_DEC);
`ifdef MC_JAL_EN
    applyStimulus("jal_jump",     1, 6'h03, 6'h00, 0, 1, E_JAL);
    applyStimulus("j_after_jal_fetch",  1, 6'h02, 6'h00, 0, 1, E_FR);
    applyStimulus("j_after_jal_decode", 1, 6'h02, 6'h00, 0, 1, E_DEC);
    applyStimulus("j_after_jal_nolink", 1, 6'h02, 6'h00, 0, 1, E_JMP);
    applyStimulus("jal_fetch_again", 1, 6'h00, 6'h00, 1, 1, E_FR);
`else
    applyStimulus("jal_illegal_halt", 1, 6'h03, 6'h00, 0, 1, E_HILL);
    applyStimulus("jal_reset",        0, 6'h00, 6'h00, 1, 1, E_HILL);
    applyStimulus("jal_after_reset",  1, 6'h00, 6'h00, 1, 1, E_FR);
`endif

    // instr_zero halts without an error flag; one reset edge returns to a clean FETCH
    applyStimulus("zero_decode",  1, 6'h23, 6'h00, 1, 1, E_DEC);
    applyStimulus("zero_halt",    1, 6'h23, 6'h00, 1, 1, E_HLT);
    applyStimulus("zero_reset",   0, 6'h23, 6'h00, 0, 1, E_HLT);
    applyStimulus("zero_after_reset", 1, 6'h23, 6'h00, 0, 1, E_FR);

    // MEMRD never ready: MAX_WAIT=4 instance halts after exactly four MEMRD cycles
    applyStimulus("to_decode", 1, 6'h23, 6'h00, 0, 1, E_DEC, 1'b1);
    applyStimulus("to_memadr", 1, 6'h23, 6'h00, 0, 1, E_MADR, 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("to_memrd_%0d", i), 1, 6'h23, 6'h00, 0, 0, E_MRD, 1'b1);
    applyStimulus("to_halt",        1, 6'h23, 6'h00, 0, 0, E_HTO, 1'b1);
    applyStimulus("to_wide_waits",  1, 6'h23, 6'h00, 0, 0, E_MRD);
    applyStimulus("to_wide_ready",  1, 6'h23, 6'h00, 0, 1, E_MRD);
    applyStimulus("to_wide_memwb",  1, 6'h23, 6'h00, 0, 1, E_MWB);
    applyStimulus("to_halt_holds",  1, 6'h23, 6'h00, 0, 1, E_HTO, 1'b1);
    applyStimulus("to_reset",       0, 6'h23, 6'h00, 0, 1, E_HTO, 1'b1);
    applyStimulus("to_after_reset", 1, 6'h23, 6'h00, 0, 0, E_FW, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum consecutive cycles a memory state waits for mem_ready before timing out (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; instr_zero  in  1  IR == 32'h0.
REQ-005 mem_ready  in  1  memory completes the current access this cycle.
REQ-006 mem_req, mem_write, iord, ir_write  out  1 each  memory strobe, write enable, address select (0=PC, 1=ALUOut), IR load.
REQ-007 pc_write, pc_write_cond, invert_zero  out  1 each  unconditional PC load, branch PC load, BNE zero inversion.
REQ-008 regdst, regwrite, memtoreg, link  out  1 each  register-file controls (link: write $31 with PC).
REQ-009 alusrc_a  out  1  (0=PC, 1=rs); alusrc_b  out  2  (0=rt, 1=4, 2=signext imm, 3=imm<<2); aluop  out  4  mips.h ALU_* code.
REQ-010 pcsrc  out  2  (0=ALU result, 1=ALUOut, 2=jump target); state  out  4  current state; halted, err_illegal, err_timeout  out  1 each.

Function
REQ-011 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, HALT; all outputs decoded from state, except ir_write/pc_write in FETCH, which equal mem_ready.
REQ-012 FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=1, aluop=ALU_add, pcsrc=0; on mem_ready, assert ir_write and pc_write, go to DECODE; otherwise stay.
REQ-013 DECODE: alusrc_a=0, alusrc_b=3, aluop=ALU_add; instr_zero -> HALT; opcode 0x00 -> EXEC; 0x23/0x2B -> MEMADR; 0x08/0x0D -> IMMEX; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; any other opcode -> HALT with err_illegal=1.
REQ-014 MEMADR: alusrc_a=1, alusrc_b=2, aluop=ALU_add; LW (0x23) -> MEMRD; SW (0x2B) -> MEMWR.
REQ-015 MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
REQ-016 MEMWR: mem_req=1, mem_write=1, iord=1; on mem_ready -> FETCH.
REQ-017 EXEC: alusrc_a=1, alusrc_b=0; aluop from funct (0x20 ALU_add, 0x22 ALU_sub, 0x24 ALU_AND, 0x25 ALU_OR, 0x2A ALU_slt); other funct -> HALT with err_illegal=1; else -> ALUWB. ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-018 IMMEX: alusrc_a=1, alusrc_b=2, aluop=ALU_add (ADDI) or ALU_OR (ORI) -> IMMWB. IMMWB: regwrite=1, regdst=0 -> FETCH.
REQ-019 BRANCH: alusrc_a=1, alusrc_b=0, aluop=ALU_sub, pc_write_cond=1, pcsrc=1, invert_zero = (opcode==0x05) -> FETCH.
REQ-020 JUMP: pc_write=1, pcsrc=2 -> FETCH.
REQ-021 Deasserted defaults in every state: strobes 0, selects 0, aluop=ALU_undef.
REQ-022 Latencies at zero wait: branch/jump 3 cycles; R-type, immediate, SW 4; LW 5; each wait cycle adds 1.
REQ-023 8-bit wait counter: cleared on entry to FETCH/MEMRD/MEMWR and on mem_ready; increments each cycle in those states without mem_ready; on the cycle the count equals MAX_WAIT-1 without mem_ready, go to HALT with err_timeout=1.
REQ-024 HALT: all strobes 0, halted=1; exits only by reset; error flags remain set while halted.
REQ-025 mem_ready is ignored in any state that does not assert mem_req.
REQ-026 opcode/funct are sampled only in DECODE, EXEC, MEMADR, IMMEX and BRANCH; IR stability there is the datapath's duty.

Reset
REQ-027 rst_n low at posedge clk: state=FETCH, counter=0, halted/err_illegal/err_timeout=0, whatever the current state, including mid-wait and HALT.
REQ-028 While rst_n is low, mem_req, mem_write, ir_write, pc_write, pc_write_cond and regwrite are forced 0 combinationally.

Configuration
REQ-029 Macro MC_JAL_EN defined: DECODE opcode 0x03 -> JUMP with link=1, regwrite=1, memtoreg=0 (writes $31 = PC+4) alongside pc_write=1, pcsrc=2.
REQ-030 MC_JAL_EN undefined: opcode 0x03 is illegal (HALT, err_illegal=1); link is tied to 0.

Verification
REQ-031 Reset, then LW (opcode 0x23) with mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; exactly one regwrite pulse with memtoreg=1.
REQ-032 FETCH with mem_ready held low 3 cycles (MAX_WAIT=15) -> state stays FETCH for 3 cycles; ir_write/pc_write pulse once, on the ready cycle.
REQ-033 MEMRD with mem_ready never asserted, MAX_WAIT=4 -> HALT after exactly 4 MEMRD cycles; err_timeout=1, halted=1, mem_req=0.
REQ-034 BNE (0x05) -> BRANCH asserts pc_write_cond=1, invert_zero=1, aluop=ALU_sub; BEQ (0x04) gives invert_zero=0.
REQ-035 opcode 0x03, with and without MC_JAL_EN -> JUMP with link=1, regwrite=1 vs. HALT with err_illegal=1.
REQ-036 instr_zero=1 in DECODE -> HALT; then rst_n low for one edge mid-HALT -> FETCH, all flags 0, mem_req=1 on the next cycle.
